// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Saturating wait-cycle counter; expired flags the cycle that would make the count reach TIMEOUT.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Firing one cycle early lets the fault register land right after the last idle cycle.
  assign expired = count & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || expired) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues PC reads, latches the IR, handles redirects and memory timeouts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              redirect,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              pc_write,
  output logic              fetch_fault
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              busy;
  logic              expired;
  logic              load_ir;
  logic              load_addr;
  logic              fault_d;

  assign busy     = (state_q == REQ) || (state_q == DISCARD);
  assign mem_addr = addr_q;
  assign pc_write = (state_q == REQ) & mem_ready & ~redirect;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (~busy | mem_ready),
    .count   (busy & ~mem_ready),
    .expired (expired)
  );

  // Next-state and register-load decisions.
  always_comb begin
    state_d   = state_q;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req && !redirect) begin
          state_d   = REQ;
          load_addr = 1'b1;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = redirect ? IDLE : FULL;
          load_ir = ~redirect;
        end else if (expired) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      FULL: begin
        if (redirect) begin
          state_d = IDLE;
        end else if (ir_ack) begin
          if (fetch_req) begin
            state_d   = REQ;
            load_addr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      mem_rd      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (load_addr) addr_q <= pc;
      if (load_ir) begin
        ir    <= mem_rdata;
        ir_pc <= addr_q;
      end
      ir_valid    <= (state_d == FULL);
      mem_rd      <= (state_d == REQ) || (state_d == DISCARD);
      fetch_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: transaction driver predicts IR loads and faults, negedge monitor checks them.
module tb_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int          TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          fetch_req = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ack = 1'b0;
  logic          pc_write;
  logic          fetch_fault;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .redirect    (redirect),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ack      (ir_ack),
    .pc_write    (pc_write),
    .fetch_fault (fetch_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_fault;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            pcw_seen = 0;
  int            pcw_exp = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on each new IR load or fault pulse.
  logic          prev_v = 1'b0;
  logic          prev_f = 1'b0;
  logic [DW-1:0] last_ir = '0;
  logic [AW-1:0] last_ir_pc = '0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
      prev_f = 1'b0;
    end else begin
      if (pc_write) pcw_seen++;
      if (mem_rd) check("mem_addr_stable", 32'(mem_addr), 32'(exp_addr));
      if (fetch_fault) begin
        check("fault_one_cycle", 32'(prev_f), 32'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fault_unexpected: fault seen, scoreboard empty at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("fault_kind", 32'(e.is_fault), 32'(1));
        end
      end
      if (ir_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ir_unexpected: ir 0x%0h loaded, scoreboard empty at %0t", ir, $time);
        end else begin
          e = exp_q.pop_front();
          check("ir_kind", 32'(e.is_fault), 32'(0));
          check("ir_data", 32'(ir), 32'(e.data));
          check("ir_pc", 32'(ir_pc), 32'(e.addr));
        end
        last_ir    = ir;
        last_ir_pc = ir_pc;
      end else if (ir_valid && prev_v) begin
        check("ir_hold", 32'(ir), 32'(last_ir));
        check("ir_pc_hold", 32'(ir_pc), 32'(last_ir_pc));
      end
      prev_v = ir_valid;
      prev_f = fetch_fault;
    end
  end

  // Issue a request from IDLE; returns in the first REQ cycle.
  task automatic start_req(input logic [AW-1:0] a);
    pc        = a;
    fetch_req = 1'b1;
    redirect  = 1'b0;
    exp_addr  = a;
    tick();
    fetch_req = 1'b0;
  endtask

  // Memory side of one read: waits non-ready cycles, optional redirect in REQ cycle redir_at.
  task automatic serve(input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits,
                       input int redir_at, input logic [AW-1:0] junk);
    int nwait;
    nwait = (waits >= TO) ? TO : waits;
    for (int k = 1; k <= nwait; k++) begin
      mem_ready = 1'b0;
      redirect  = (k == redir_at);
      pc        = junk;
      #1;
      check("mem_rd_held", 32'(mem_rd), 32'(1));
      check("pc_write_wait", 32'(pc_write), 32'(0));
      if (waits >= TO && k == nwait) exp_q.push_back('{is_fault: 1'b1, data: '0, addr: a});
      tick();
    end
    redirect = 1'b0;
    if (waits >= TO) begin
      check("fault_pulse", 32'(fetch_fault), 32'(1));
      check("mem_rd_after_fault", 32'(mem_rd), 32'(0));
      check("ir_valid_after_fault", 32'(ir_valid), 32'(0));
      return;
    end
    mem_ready = 1'b1;
    mem_rdata = d;
    redirect  = (redir_at == waits + 1);
    #1;
    check("mem_rd_ready_cycle", 32'(mem_rd), 32'(1));
    check("pc_write_ready", 32'(pc_write), 32'(redir_at == 0));
    if (redir_at == 0) begin
      exp_q.push_back('{is_fault: 1'b0, data: d, addr: a});
      pcw_exp++;
    end
    tick();
    mem_ready = 1'b0;
    redirect  = 1'b0;
    mem_rdata = 16'($urandom);
    check("ir_valid_after_read", 32'(ir_valid), 32'(redir_at == 0));
    check("mem_rd_after_read", 32'(mem_rd), 32'(0));
  endtask

  // Leave FULL: 0 ack, 1 ack+fetch, 2 redirect+ack, 3 redirect, 4 redirect+ack+fetch.
  task automatic finish_ir(input int mode, input logic [AW-1:0] next_a);
    ir_ack    = (mode == 0) || (mode == 1) || (mode == 2) || (mode == 4);
    fetch_req = (mode == 1) || (mode == 4);
    redirect  = (mode >= 2);
    pc        = next_a;
    if (mode == 1) exp_addr = next_a;
    tick();
    ir_ack    = 1'b0;
    fetch_req = 1'b0;
    redirect  = 1'b0;
    check("ir_valid_cleared", 32'(ir_valid), 32'(0));
    check("mem_rd_after_full", 32'(mem_rd), 32'(mode == 1));
  endtask

  initial begin
    logic [AW-1:0] a, next_a;
    logic [DW-1:0] d;
    int            waits, redir_at, mode;
    bit            pending;

    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_ir", 32'(ir), 32'(0));
    check("rst_ir_pc", 32'(ir_pc), 32'(0));
    check("rst_ir_valid", 32'(ir_valid), 32'(0));
    check("rst_fault", 32'(fetch_fault), 32'(0));
    check("rst_pc_write", 32'(pc_write), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Redirect blocks a request in IDLE.
    pc        = 16'h0040;
    fetch_req = 1'b1;
    redirect  = 1'b1;
    tick();
    fetch_req = 1'b0;
    redirect  = 1'b0;
    check("idle_redirect_block", 32'(mem_rd), 32'(0));

    // Zero-wait fetch, minimum latency.
    start_req(16'h0010);
    check("zw_mem_rd", 32'(mem_rd), 32'(1));
    check("zw_mem_addr", 32'(mem_addr), 32'(16'h0010));
    serve(16'h0010, 16'hA5C3, 0, 0, 16'h0010);
    check("zw_ir", 32'(ir), 32'(16'hA5C3));
    check("zw_ir_pc", 32'(ir_pc), 32'(16'h0010));
    finish_ir(0, 16'h0011);

    // Wait states with pc disturbed, then back-to-back, then redirect concurrent with ack.
    start_req(16'h0020);
    serve(16'h0020, 16'h1234, 3, 0, 16'h0099);
    finish_ir(1, 16'h0030);
    check("b2b_mem_addr", 32'(mem_addr), 32'(16'h0030));
    serve(16'h0030, 16'h5678, 0, 0, 16'h0031);
    finish_ir(2, 16'h0031);

    // Redirect in the 2nd REQ cycle, data two cycles later is dropped.
    start_req(16'h0050);
    serve(16'h0050, 16'hDEAD, 3, 2, 16'h0051);

    // Timeout, then ready on the limit cycle wins.
    start_req(16'h0060);
    serve(16'h0060, 16'h0000, TO, 0, 16'h0061);
    start_req(16'h0070);
    serve(16'h0070, 16'hBEEF, TO - 1, 0, 16'h0071);
    finish_ir(0, 16'h0072);

    // Async reset mid-REQ.
    start_req(16'h0080);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mem_rd", 32'(mem_rd), 32'(0));
    check("arst_ir_valid", 32'(ir_valid), 32'(0));
    check("arst_mem_addr", 32'(mem_addr), 32'(0));
    check("arst_ir", 32'(ir), 32'(0));
    check("arst_ir_pc", 32'(ir_pc), 32'(0));
    check("arst_fault", 32'(fetch_fault), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Randomized transactions.
    pending = 1'b0;
    next_a  = '0;
    for (int n = 0; n < 60; n++) begin
      a     = pending ? next_a : 16'($urandom);
      d     = 16'($urandom);
      waits = ($urandom_range(0, 99) < 75) ? int'($urandom_range(0, TO - 1))
                                           : int'($urandom_range(TO, TO + 2));
      redir_at = 0;
      if ($urandom_range(0, 5) == 0)
        redir_at = (waits >= TO) ? int'($urandom_range(1, TO - 1)) : int'($urandom_range(1, waits + 1));
      if (!pending) start_req(a);
      serve(a, d, waits, redir_at, 16'($urandom));
      pending = 1'b0;
      if (waits < TO && redir_at == 0) begin
        repeat ($urandom_range(0, 3)) begin
          fetch_req = 1'($urandom);
          pc        = 16'($urandom);
          tick();
          check("full_hold_valid", 32'(ir_valid), 32'(1));
        end
        fetch_req = 1'b0;
        mode      = int'($urandom_range(0, 4));
        next_a    = 16'($urandom);
        finish_ir(mode, next_a);
        pending = (mode == 1);
      end
    end
    if (pending) begin
      serve(next_a, 16'h4321, 0, 0, 16'h0000);
      finish_ir(0, 16'h0000);
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("pc_write_count", 32'(pcw_seen), 32'(pcw_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
